// File: rtl/mopshub_seq_pkg.sv
// Shared types and helpers for the MOPSHUB bring-up/test sequencer.
package mopshub_seq_pkg;

  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_TRIM    = 4'd1,
    S_SIGNON  = 4'd2,
    S_RX      = 4'd3,
    S_RX_TURN = 4'd4,
    S_ENDWAIT = 4'd5,
    S_GAP     = 4'd6,
    S_TX      = 4'd7,
    S_TX_TURN = 4'd8,
    S_ADV     = 4'd9,
    S_DONE    = 4'd10
  } seq_state_t;

  localparam logic [2:0] PH_IDLE   = 3'd0;
  localparam logic [2:0] PH_TRIM   = 3'd1;
  localparam logic [2:0] PH_SIGNON = 3'd2;
  localparam logic [2:0] PH_RX     = 3'd3;
  localparam logic [2:0] PH_GAP    = 3'd4;
  localparam logic [2:0] PH_TX     = 3'd5;
  localparam logic [2:0] PH_ADV    = 3'd6;
  localparam logic [2:0] PH_DONE   = 3'd7;

  localparam int TIMER_W = 16;

  // Requested bus count: 0 means one bus, anything above the build size is capped.
  function automatic logic [4:0] clamp_buses(input logic [4:0] req, input logic [5:0] max_buses);
    if (req == 5'd0)
      return 5'd1;
    else if ({1'b0, req} > max_buses)
      return max_buses[4:0];
    else
      return req;
  endfunction

  // Externally visible phase code; the TURN states report the phase of their test.
  function automatic logic [2:0] phase_of(input seq_state_t s);
    case (s)
      S_TRIM:               return PH_TRIM;
      S_SIGNON:             return PH_SIGNON;
      S_RX, S_RX_TURN:      return PH_RX;
      S_ENDWAIT, S_GAP:     return PH_GAP;
      S_TX, S_TX_TURN:      return PH_TX;
      S_ADV:                return PH_ADV;
      S_DONE:               return PH_DONE;
      default:              return PH_IDLE;
    endcase
  endfunction

endpackage

// File: rtl/mopshub_test_sequencer_if.sv
// Test-control bundle between the sequencer and the hub/data-generator side.
interface mopshub_test_sequencer_if #(parameter int N_BUSES = 2);

  logic               start;
  logic [4:0]         n_buses_active;
  logic               en_trim;
  logic               en_rx;
  logic               en_tx;
  logic               en_adv;
  logic               end_power_init;
  logic               sign_on_sig;
  logic               test_rx_end;
  logic               test_tx_end;
  logic               costum_msg_end;
  logic               osc_auto_trim;
  logic               test_rx;
  logic               test_tx;
  logic               test_advanced;
  logic               endwait_all;
  logic [4:0]         bus_sel;
  logic [2:0]         phase;
  logic               busy;
  logic               done;
  logic               timeout_err;
  logic [N_BUSES-1:0] fail_mask;

  modport master (
    input  start, n_buses_active, en_trim, en_rx, en_tx, en_adv,
           end_power_init, sign_on_sig, test_rx_end, test_tx_end, costum_msg_end,
    output osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all,
           bus_sel, phase, busy, done, timeout_err, fail_mask
  );

  modport slave (
    output start, n_buses_active, en_trim, en_rx, en_tx, en_adv,
           end_power_init, sign_on_sig, test_rx_end, test_tx_end, costum_msg_end,
    input  osc_auto_trim, test_rx, test_tx, test_advanced, endwait_all,
           bus_sel, phase, busy, done, timeout_err, fail_mask
  );

endinterface

// File: rtl/seq_timer.sv
// Loadable down-counter shared by the ENDWAIT/GAP intervals and the step timeout.
// A clear loads the counter; expired is the terminal count (zero) and holds there.
module seq_timer
  import mopshub_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic [TIMER_W-1:0] load_val,
  output logic               expired
);

  logic [TIMER_W-1:0] count_q;

  // Load on clear, otherwise count down and park at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else if (clear)
      count_q <= load_val;
    else if (count_q != '0)
      count_q <= count_q - 1'b1;
  end

  assign expired = (count_q == '0);

endmodule

// File: rtl/mopshub_test_sequencer.sv
// MOPSHUB bring-up/test sequencer: trim, sign-on, per-bus RX, endwait, gap,
// per-bus TX and custom-message test, with per-step timeouts and a fail record.
//
// state     | meaning
// ----------+------------------------------------------------------------
// S_IDLE    | waiting for start
// S_TRIM    | osc_auto_trim high until end_power_init
// S_SIGNON  | waiting for sign_on_sig
// S_RX      | test_rx high for bus_sel until test_rx_end
// S_RX_TURN | one low cycle between RX buses
// S_ENDWAIT | endwait_all pulse
// S_GAP     | idle gap before TX
// S_TX      | test_tx high for bus_sel until test_tx_end
// S_TX_TURN | one low cycle between TX buses
// S_ADV     | test_advanced high until costum_msg_end
// S_DONE    | one-cycle done pulse
module mopshub_test_sequencer
  import mopshub_seq_pkg::*;
#(
  parameter int N_BUSES        = 2,
  parameter int GAP_CYCLES     = 120,
  parameter int ENDWAIT_CYCLES = 1,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input logic                      clk,
  input logic                      rst,
  mopshub_test_sequencer_if.master ctl
);

  // Timer loads are "cycles - 1" so expiry lands on the N-th cycle in the state.
  localparam logic [TIMER_W-1:0] TO_LOAD  = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] EW_LOAD  = TIMER_W'(ENDWAIT_CYCLES - 1);
  localparam logic [TIMER_W-1:0] GAP_LOAD = TIMER_W'(GAP_CYCLES - 1);

  seq_state_t           state_q, next_state;
  logic                 en_rx_q, en_tx_q, en_adv_q;
  logic [4:0]           n_act_q;
  logic [4:0]           bus_sel_q, bus_sel_d;
  logic                 to_q, to_d;
  logic [N_BUSES-1:0]   fail_q, fail_d;
  logic                 to_set, fail_set;
  logic                 last_bus;
  logic                 timer_clear, expired;
  logic [TIMER_W-1:0]   timer_load;
  logic                 start_ok;

  logic       osc_auto_trim_q, test_rx_q, test_tx_q, test_advanced_q, endwait_all_q;
  logic       busy_q, done_q;
  logic [2:0] phase_q;

  assign start_ok = (state_q == S_IDLE) && ctl.start;
  assign last_bus = (bus_sel_q == n_act_q - 5'd1);

  seq_timer u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (timer_clear),
    .load_val (timer_load),
    .expired  (expired)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state_q <= S_IDLE;
    else
      state_q <= next_state;
  end

  // Next-state logic; a step timeout behaves like its strobe but flags the failure.
  always_comb begin
    next_state = state_q;
    to_set     = 1'b0;
    fail_set   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ctl.start)
          next_state = ctl.en_trim ? S_TRIM : S_SIGNON;
      end
      S_TRIM: begin
        if (ctl.end_power_init)
          next_state = S_SIGNON;
        else if (expired) begin
          to_set     = 1'b1;
          next_state = S_DONE;
        end
      end
      S_SIGNON: begin
        if (ctl.sign_on_sig)
          next_state = en_rx_q  ? S_RX  :
                       en_tx_q  ? S_TX  :
                       en_adv_q ? S_ADV : S_DONE;
        else if (expired) begin
          to_set     = 1'b1;
          next_state = S_DONE;
        end
      end
      S_RX: begin
        if (ctl.test_rx_end || expired) begin
          to_set     = !ctl.test_rx_end;
          fail_set   = !ctl.test_rx_end;
          next_state = last_bus ? S_ENDWAIT : S_RX_TURN;
        end
      end
      S_RX_TURN: next_state = S_RX;
      S_ENDWAIT: begin
        if (expired)
          next_state = S_GAP;
      end
      S_GAP: begin
        if (expired)
          next_state = en_tx_q  ? S_TX  :
                       en_adv_q ? S_ADV : S_DONE;
      end
      S_TX: begin
        if (ctl.test_tx_end || expired) begin
          to_set     = !ctl.test_tx_end;
          fail_set   = !ctl.test_tx_end;
          next_state = !last_bus ? S_TX_TURN :
                       en_adv_q  ? S_ADV     : S_DONE;
        end
      end
      S_TX_TURN: next_state = S_TX;
      S_ADV: begin
        if (ctl.costum_msg_end || expired) begin
          to_set     = !ctl.costum_msg_end;
          fail_set   = !ctl.costum_msg_end;
          next_state = S_DONE;
        end
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Timer restarts on every state change, TURN cycles included.
  always_comb begin
    timer_clear = (next_state != state_q);
    case (next_state)
      S_ENDWAIT: timer_load = EW_LOAD;
      S_GAP:     timer_load = GAP_LOAD;
      default:   timer_load = TO_LOAD;
    endcase
  end

  // Bus select: zero on entry to a test, advance when leaving a TURN cycle.
  always_comb begin
    case (next_state)
      S_RX, S_TX: begin
        if (state_q == S_RX_TURN || state_q == S_TX_TURN)
          bus_sel_d = bus_sel_q + 5'd1;
        else if (state_q == next_state)
          bus_sel_d = bus_sel_q;
        else
          bus_sel_d = 5'd0;
      end
      S_RX_TURN, S_TX_TURN: bus_sel_d = bus_sel_q;
      default:              bus_sel_d = 5'd0;
    endcase
  end

  // Error record: cleared by an accepted start, otherwise sticky.
  always_comb begin
    fail_d = fail_q;
    to_d   = to_q;
    if (start_ok) begin
      fail_d = '0;
      to_d   = 1'b0;
    end else begin
      if (to_set)
        to_d = 1'b1;
      for (int i = 0; i < N_BUSES; i++)
        if (fail_set && bus_sel_q == 5'(i))
          fail_d[i] = 1'b1;
    end
  end

  // Run configuration captured when a sequence is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      en_rx_q  <= 1'b0;
      en_tx_q  <= 1'b0;
      en_adv_q <= 1'b0;
      n_act_q  <= 5'd1;
    end else if (start_ok) begin
      en_rx_q  <= ctl.en_rx;
      en_tx_q  <= ctl.en_tx;
      en_adv_q <= ctl.en_adv;
      n_act_q  <= clamp_buses(ctl.n_buses_active, 6'(N_BUSES));
    end
  end

  // Registered outputs decoded from the next state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus_sel_q       <= 5'd0;
      to_q            <= 1'b0;
      fail_q          <= '0;
      osc_auto_trim_q <= 1'b0;
      test_rx_q       <= 1'b0;
      test_tx_q       <= 1'b0;
      test_advanced_q <= 1'b0;
      endwait_all_q   <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      phase_q         <= PH_IDLE;
    end else begin
      bus_sel_q       <= bus_sel_d;
      to_q            <= to_d;
      fail_q          <= fail_d;
      osc_auto_trim_q <= (next_state == S_TRIM);
      test_rx_q       <= (next_state == S_RX);
      test_tx_q       <= (next_state == S_TX);
      test_advanced_q <= (next_state == S_ADV);
      endwait_all_q   <= (next_state == S_ENDWAIT);
      busy_q          <= (next_state != S_IDLE);
      done_q          <= (next_state == S_DONE);
      phase_q         <= phase_of(next_state);
    end
  end

  assign ctl.osc_auto_trim = osc_auto_trim_q;
  assign ctl.test_rx       = test_rx_q;
  assign ctl.test_tx       = test_tx_q;
  assign ctl.test_advanced = test_advanced_q;
  assign ctl.endwait_all   = endwait_all_q;
  assign ctl.bus_sel       = bus_sel_q;
  assign ctl.phase         = phase_q;
  assign ctl.busy          = busy_q;
  assign ctl.done          = done_q;
  assign ctl.timeout_err   = to_q;
  assign ctl.fail_mask     = fail_q;

endmodule

// File: tb/tb_mopshub_test_sequencer.sv
// Bench for mopshub_test_sequencer: scenario table plus random scenarios, each
// compared as a run-length trace against a segment-level model of the flow.
module tb_mopshub_test_sequencer;

  localparam int N   = 2;
  localparam int GAP = 120;
  localparam int EW  = 1;
  localparam int TO  = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;

  mopshub_test_sequencer_if #(.N_BUSES(N)) ctl();

  mopshub_test_sequencer #(
    .N_BUSES(N), .GAP_CYCLES(GAP), .ENDWAIT_CYCLES(EW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .ctl (ctl)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit       en_trim, en_rx, en_tx, en_adv;
    bit [4:0] n_req;
    int       delay;
    bit [6:0] withhold;   // 0 trim, 1 signon, 2..3 rx bus, 4..5 tx bus, 6 adv
    int       restart_at;
    bit [1:0] exp_fail;
    bit       exp_to;
  } scen_t;

  typedef struct {
    bit [14:0] key;
    int        len;
  } seg_t;

  seg_t exp_q[$];
  seg_t got_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // key = {phase, bus_sel, trim, rx, tx, adv, endwait, done, busy}
  function automatic bit [14:0] mk_key(input int ph, input int bus, input bit trim, input bit rx,
                                       input bit tx, input bit adv, input bit ew, input bit dn);
    return {3'(ph), 5'(bus), trim, rx, tx, adv, ew, dn, (ph != 0)};
  endfunction

  function automatic bit [14:0] dut_key();
    return {ctl.phase, ctl.bus_sel, ctl.osc_auto_trim, ctl.test_rx, ctl.test_tx,
            ctl.test_advanced, ctl.endwait_all, ctl.done, ctl.busy};
  endfunction

  function automatic logic [23:0] all_outs();
    return {ctl.osc_auto_trim, ctl.test_rx, ctl.test_tx, ctl.test_advanced, ctl.endwait_all,
            ctl.bus_sel, ctl.phase, ctl.busy, ctl.done, ctl.timeout_err, ctl.fail_mask,
            6'd0};
  endfunction

  task automatic push(input bit [14:0] k, input int len);
    seg_t s;
    s.key = k;
    s.len = len;
    exp_q.push_back(s);
  endtask

  // A step lasts until its strobe (delay cycles) or the timeout, strobe winning a tie.
  task automatic step_len(input bit wh, input int d, output int len, output bit f);
    if (wh || d > TO) begin
      len = TO;
      f   = 1'b1;
    end else begin
      len = d;
      f   = 1'b0;
    end
  endtask

  task automatic build_model(input scen_t s, output bit [1:0] fm, output bit to);
    int n, d;
    bit f, abort;
    exp_q.delete();
    fm = 2'b00;
    to = 1'b0;
    abort = 1'b0;
    n = (s.n_req == 0) ? 1 : ((int'(s.n_req) > N) ? N : int'(s.n_req));
    if (s.en_trim) begin
      step_len(s.withhold[0], s.delay, d, f);
      push(mk_key(1, 0, 1, 0, 0, 0, 0, 0), d);
      if (f) begin to = 1'b1; abort = 1'b1; end
    end
    if (!abort) begin
      step_len(s.withhold[1], s.delay, d, f);
      push(mk_key(2, 0, 0, 0, 0, 0, 0, 0), d);
      if (f) begin to = 1'b1; abort = 1'b1; end
    end
    if (!abort && s.en_rx) begin
      for (int b = 0; b < n; b++) begin
        step_len(s.withhold[2 + b], s.delay, d, f);
        push(mk_key(3, b, 0, 1, 0, 0, 0, 0), d);
        if (f) begin to = 1'b1; fm[b] = 1'b1; end
        if (b < n - 1) push(mk_key(3, b, 0, 0, 0, 0, 0, 0), 1);
      end
      push(mk_key(4, 0, 0, 0, 0, 0, 1, 0), EW);
      push(mk_key(4, 0, 0, 0, 0, 0, 0, 0), GAP);
    end
    if (!abort && s.en_tx) begin
      for (int b = 0; b < n; b++) begin
        step_len(s.withhold[4 + b], s.delay, d, f);
        push(mk_key(5, b, 0, 0, 1, 0, 0, 0), d);
        if (f) begin to = 1'b1; fm[b] = 1'b1; end
        if (b < n - 1) push(mk_key(5, b, 0, 0, 0, 0, 0, 0), 1);
      end
    end
    if (!abort && s.en_adv) begin
      step_len(s.withhold[6], s.delay, d, f);
      push(mk_key(6, 0, 0, 0, 0, 1, 0, 0), d);
      if (f) begin to = 1'b1; fm[0] = 1'b1; end
    end
    push(mk_key(7, 0, 0, 0, 0, 0, 0, 1), 1);
  endtask

  task automatic clear_strobes();
    ctl.end_power_init = 1'b0;
    ctl.sign_on_sig    = 1'b0;
    ctl.test_rx_end    = 1'b0;
    ctl.test_tx_end    = 1'b0;
    ctl.costum_msg_end = 1'b0;
  endtask

  task automatic run_scen(input scen_t s, input string tag, input bit use_tab);
    bit [1:0]  mfail, efail;
    bit        mto, eto, fin, wh;
    bit [14:0] k, cur;
    int        cur_len, n_cmp;
    int        c_trim, c_sign, c_rx, c_tx, c_adv;
    seg_t      sg;
    build_model(s, mfail, mto);
    efail = use_tab ? s.exp_fail : mfail;
    eto   = use_tab ? s.exp_to   : mto;
    got_q.delete();
    cur = '0; cur_len = 0; fin = 1'b0;
    c_trim = 0; c_sign = 0; c_rx = 0; c_tx = 0; c_adv = 0;
    @(negedge clk);
    ctl.en_trim = s.en_trim;
    ctl.en_rx = s.en_rx;
    ctl.en_tx = s.en_tx;
    ctl.en_adv = s.en_adv;
    ctl.n_buses_active = s.n_req;
    ctl.start = 1'b1;
    for (int cyc = 1; cyc <= 4000 && !fin; cyc++) begin
      @(negedge clk);
      ctl.start = (cyc == s.restart_at);
      clear_strobes();
      k = dut_key();
      if (ctl.phase == 3'd0) begin
        fin = 1'b1;
      end else begin
        if (cur_len > 0 && k == cur) cur_len++;
        else begin
          if (cur_len > 0) begin sg.key = cur; sg.len = cur_len; got_q.push_back(sg); end
          cur = k;
          cur_len = 1;
        end
        c_trim = ctl.osc_auto_trim ? c_trim + 1 : 0;
        if (c_trim == s.delay && !s.withhold[0]) ctl.end_power_init = 1'b1;
        c_sign = (ctl.phase == 3'd2) ? c_sign + 1 : 0;
        if (c_sign == s.delay && !s.withhold[1]) ctl.sign_on_sig = 1'b1;
        c_rx = ctl.test_rx ? c_rx + 1 : 0;
        wh = 1'b0;
        if (ctl.bus_sel < 5'(N)) wh = s.withhold[2 + int'(ctl.bus_sel)];
        if (c_rx == s.delay && !wh) ctl.test_rx_end = 1'b1;
        c_tx = ctl.test_tx ? c_tx + 1 : 0;
        wh = 1'b0;
        if (ctl.bus_sel < 5'(N)) wh = s.withhold[4 + int'(ctl.bus_sel)];
        if (c_tx == s.delay && !wh) ctl.test_tx_end = 1'b1;
        c_adv = ctl.test_advanced ? c_adv + 1 : 0;
        if (c_adv == s.delay && !s.withhold[6]) ctl.costum_msg_end = 1'b1;
      end
    end
    ctl.start = 1'b0;
    if (cur_len > 0) begin sg.key = cur; sg.len = cur_len; got_q.push_back(sg); end
    check({tag, " reached_idle"}, 64'(fin), 64'd1);
    check({tag, " seg_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n_cmp; i++) begin
      check($sformatf("%s seg%0d_key", tag, i), 64'(got_q[i].key), 64'(exp_q[i].key));
      check($sformatf("%s seg%0d_len", tag, i), 64'(got_q[i].len), 64'(exp_q[i].len));
    end
    check({tag, " fail_mask"}, 64'(ctl.fail_mask), 64'(efail));
    check({tag, " timeout_err"}, 64'(ctl.timeout_err), 64'(eto));
    repeat (3) @(negedge clk);
    check({tag, " errs_held"}, 64'({ctl.fail_mask, ctl.timeout_err, ctl.busy}), 64'({efail, eto, 1'b0}));
    if (!fin) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end
  endtask

  scen_t tab[12];
  scen_t rs;
  bit    saw_done, ok;

  initial begin
    //           trim rx tx adv n_req  delay withhold  rst_at fail  to
    tab[0]  = '{1, 1, 1, 1, 5'd2,  50,  7'b0000000, 0,  2'b00, 0};
    tab[1]  = '{1, 1, 1, 1, 5'd2,  50,  7'b0100000, 0,  2'b10, 1};
    tab[2]  = '{1, 1, 1, 1, 5'd2,  50,  7'b0000010, 0,  2'b00, 1};
    tab[3]  = '{0, 0, 1, 1, 5'd2,  10,  7'b0000000, 0,  2'b00, 0};
    tab[4]  = '{1, 1, 1, 1, 5'd0,  5,   7'b0000000, 0,  2'b00, 0};
    tab[5]  = '{1, 1, 1, 1, 5'd31, 5,   7'b0000000, 20, 2'b00, 0};
    tab[6]  = '{1, 1, 0, 0, 5'd1,  200, 7'b0000000, 0,  2'b00, 0};
    tab[7]  = '{1, 1, 0, 0, 5'd1,  201, 7'b0000000, 0,  2'b00, 1};
    tab[8]  = '{0, 1, 0, 1, 5'd31, 20,  7'b0001000, 0,  2'b10, 1};
    tab[9]  = '{0, 0, 0, 1, 5'd2,  8,   7'b1000000, 0,  2'b01, 1};
    tab[10] = '{0, 0, 0, 0, 5'd2,  3,   7'b0000000, 0,  2'b00, 0};
    tab[11] = '{1, 1, 1, 1, 5'd2,  7,   7'b0000100, 0,  2'b01, 1};

    ctl.start = 1'b0;
    ctl.n_buses_active = 5'd0;
    ctl.en_trim = 1'b0;
    ctl.en_rx = 1'b0;
    ctl.en_tx = 1'b0;
    ctl.en_adv = 1'b0;
    clear_strobes();

    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 24'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_after_reset", all_outs(), 24'd0);

    for (int i = 0; i < 12; i++)
      run_scen(tab[i], $sformatf("tab%0d", i), 1'b1);

    // Reset in the middle of RX: outputs drop at once and no done follows.
    @(negedge clk);
    ctl.en_trim = 1'b0; ctl.en_rx = 1'b1; ctl.en_tx = 1'b1; ctl.en_adv = 1'b1;
    ctl.n_buses_active = 5'd2;
    ctl.start = 1'b1;
    @(negedge clk);
    ctl.start = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (ctl.phase == 3'd2) ok = 1'b1;
      else @(negedge clk);
    end
    ctl.sign_on_sig = 1'b1;
    @(negedge clk);
    ctl.sign_on_sig = 1'b0;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      if (ctl.test_rx) ok = 1'b1;
      else @(negedge clk);
    end
    check("rst_mid_rx reached_rx", 64'(ok), 64'd1);
    repeat (10) @(negedge clk);
    #2 rst = 1'b1;
    #1 check("rst_mid_rx outputs", all_outs(), 24'd0);
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (ctl.done) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      if (ctl.done) saw_done = 1'b1;
    end
    check("rst_mid_rx no_done", 64'(saw_done), 64'd0);
    check("rst_mid_rx idle", 64'({ctl.phase, ctl.busy}), 64'd0);
    run_scen(tab[0], "after_rst", 1'b1);

    for (int r = 0; r < 8; r++) begin
      rs.en_trim = 1'($urandom_range(0, 1));
      rs.en_rx   = 1'($urandom_range(0, 1));
      rs.en_tx   = 1'($urandom_range(0, 1));
      rs.en_adv  = 1'($urandom_range(0, 1));
      rs.n_req   = 5'($urandom_range(0, 31));
      rs.delay   = int'($urandom_range(1, 40));
      for (int j = 0; j < 7; j++)
        rs.withhold[j] = ($urandom_range(0, 7) == 0);
      rs.restart_at = ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, rs.delay)) : 0;
      rs.exp_fail = 2'b00;
      rs.exp_to   = 1'b0;
      run_scen(rs, $sformatf("rand%0d", r), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
